// File: rtl/divide_arbiter.sv
// Round-robin arbiter sharing one 26-stage 24b/24b unsigned divider.
// A tag pipe tracks requester ID and divide-by-zero alongside the data.
module divide_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  issue_en_in,
    input  logic [NUM_REQ-1:0]    req_valid_in,
    input  logic [NUM_REQ*24-1:0] req_dividend_in,
    input  logic [NUM_REQ*24-1:0] req_divisor_in,
    output logic [NUM_REQ-1:0]    req_ready_out,
    output logic                  res_valid_out,
    output logic [ID_W-1:0]       res_id_out,
    output logic                  res_overflow_out,
    output logic                  res_div_zero_out,
    output logic [25:0]           res_quotient_out,
    output logic [4:0]            outstanding_out,
    output logic                  busy_out
);

    localparam int STAGES = 26;

    typedef struct packed {
        logic [23:0] rem;
        logic [25:0] quo;
        logic [23:0] dvs;
        logic [1:0]  lo;
        logic        sat;
    } stage_t;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_id;
    logic [NUM_REQ-1:0] gnt;
    logic               fire;
    logic [23:0]        sel_dvd;
    logic [23:0]        sel_dvs;
    logic [23:0]        div_dvd;
    logic [23:0]        div_dvs;

    // Two passes: indices at or above ptr first, then the wrapped remainder.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        fire    = 1'b0;
        sel_dvd = '0;
        sel_dvs = '0;
        if (issue_en_in && !rst_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!fire && req_valid_in[i] && i >= int'(ptr)) begin
                    fire    = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_id  = ID_W'(i);
                    sel_dvd = req_dividend_in[24*i +: 24];
                    sel_dvs = req_divisor_in[24*i +: 24];
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!fire && req_valid_in[i]) begin
                    fire    = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_id  = ID_W'(i);
                    sel_dvd = req_dividend_in[24*i +: 24];
                    sel_dvs = req_divisor_in[24*i +: 24];
                end
            end
        end
    end

    assign req_ready_out = gnt;
    assign div_dvd       = fire ? sel_dvd : 24'd0;
    assign div_dvs       = fire ? sel_dvs : 24'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    // One restoring-division step per stage; the numerator is dividend << 24,
    // whose only non-zero bits below the initial remainder are dividend[1:0].
    function automatic stage_t div_step(input stage_t s);
        stage_t      n;
        logic [24:0] t;
        n    = s;
        t    = {s.rem, s.lo[1]};
        n.lo = {s.lo[0], 1'b0};
        if (t >= {1'b0, s.dvs}) begin
            n.rem = 24'(t - {1'b0, s.dvs});
            n.quo = {s.quo[24:0], 1'b1};
        end else begin
            n.rem = t[23:0];
            n.quo = {s.quo[24:0], 1'b0};
        end
        return n;
    endfunction

    stage_t seed;
    stage_t st [STAGES];

    // sat: quotient would need more than 26 bits (dividend >= 4 * divisor).
    always_comb begin
        seed     = '0;
        seed.rem = {2'b00, div_dvd[23:2]};
        seed.lo  = div_dvd[1:0];
        seed.dvs = div_dvs;
        seed.sat = ({2'b00, div_dvd[23:2]} >= div_dvs);
    end

    always_ff @(posedge clk_in) begin
        st[0] <= div_step(seed);
        for (int i = 1; i < STAGES; i++) begin
            st[i] <= div_step(st[i-1]);
        end
    end

    logic [STAGES-1:0] tag_valid;
    logic [STAGES-1:0] tag_zero;
    logic [ID_W-1:0]   tag_id [STAGES];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tag_valid <= '0;
            tag_zero  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[STAGES-2:0], fire};
            tag_zero  <= {tag_zero[STAGES-2:0], fire && (sel_dvs == 24'd0)};
            tag_id[0] <= gnt_id;
            for (int i = 1; i < STAGES; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    logic [4:0] count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
        end else begin
            case ({fire, tag_valid[STAGES-1]})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    assign res_valid_out    = tag_valid[STAGES-1];
    assign res_id_out       = tag_id[STAGES-1];
    assign res_div_zero_out = tag_zero[STAGES-1];
    assign res_overflow_out = tag_zero[STAGES-1] | st[STAGES-1].sat
                            | st[STAGES-1].quo[25];
    assign res_quotient_out = (tag_zero[STAGES-1] | st[STAGES-1].sat)
                            ? 26'h3FFFFFF : st[STAGES-1].quo;
    assign outstanding_out  = count;
    assign busy_out         = (count != 5'd0);

endmodule

// File: tb/tb_divide_arbiter.sv
// Bench for divide_arbiter: random requester traffic checked against an
// arithmetic quotient model and a round-robin grant model.
module tb_divide_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           issue_en = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*24-1:0] dvd = '0;
    logic [N*24-1:0] dvs = '0;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [W-1:0]   res_id;
    logic           res_ovf;
    logic           res_dz;
    logic [25:0]    res_quot;
    logic [4:0]     outstanding;
    logic           busy;

    divide_arbiter #(.NUM_REQ(N)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .issue_en_in(issue_en),
        .req_valid_in(req_valid),
        .req_dividend_in(dvd),
        .req_divisor_in(dvs),
        .req_ready_out(req_ready),
        .res_valid_out(res_valid),
        .res_id_out(res_id),
        .res_overflow_out(res_ovf),
        .res_div_zero_out(res_dz),
        .res_quotient_out(res_quot),
        .outstanding_out(outstanding),
        .busy_out(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int id; logic [23:0] a; logic [23:0] b; int c;} op_t;
    typedef struct {int id; logic [25:0] q; logic ovf; logic dz; int c;} res_t;
    typedef struct {int id; int c;} gnt_t;

    op_t  exp_q[$];
    res_t res_log[$];
    gnt_t grant_log[$];
    logic [47:0] opq [N][$];

    int cyc = 0;
    int mptr = 0;
    int m_out = 0;
    int last_g = -1;
    int issue_cnt = 0;
    int checks = 0;
    int passes = 0;

    function automatic void ref_div(input logic [23:0] a, input logic [23:0] b,
                                    output logic [25:0] q, output logic ovf,
                                    output logic dz);
        logic [63:0] full;
        dz   = (b == 24'd0);
        full = dz ? 64'd0 : ({40'd0, a} << 24) / {40'd0, b};
        ovf  = dz || (full >= 64'h2000000);
        q    = dz ? 26'h3FFFFFF : full[25:0];
    endfunction

    function automatic logic [47:0] rand_op();
        logic [23:0] a;
        logic [23:0] b;
        int m;
        m = $urandom_range(0, 9);
        b = 24'($urandom_range(1, 32'hFFFFFF));
        if (m < 5) a = 24'($urandom_range(0, 2 * int'(b) - 1));
        else if (m < 9) a = 24'($urandom);
        else begin
            a = 24'($urandom);
            b = 24'd0;
        end
        return {a, b};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        mptr   = 0;
        m_out  = 0;
        last_g = -1;
        for (int i = 0; i < N; i++) opq[i].delete();
        req_valid = '0;
    endtask

    // One clock: scoreboard at the falling edge, requester drive after the rise.
    task automatic tick();
        int g;
        logic [N-1:0] er;
        bit ev;
        op_t o;
        logic [25:0] eq;
        logic eo;
        logic ez;
        logic [47:0] v;
        @(negedge clk);
        last_g = -1;
        if (!rst) begin
            g  = -1;
            er = '0;
            if (issue_en) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (mptr + k) % N;
                    if (g < 0 && req_valid[idx] === 1'b1) g = idx;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            checks++;
            if (req_ready !== er)
                $display("FAIL grant cyc=%0d got %b exp %b", cyc, req_ready, er);
            else passes++;
            checks++;
            if (outstanding !== 5'(m_out))
                $display("FAIL outstanding cyc=%0d got %0d exp %0d", cyc, outstanding, m_out);
            else passes++;
            checks++;
            if (busy !== (m_out != 0))
                $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, m_out != 0);
            else passes++;
            ev = exp_q.size() > 0 && exp_q[0].c + 26 == cyc;
            checks++;
            if (res_valid !== ev)
                $display("FAIL res_valid cyc=%0d got %b exp %b", cyc, res_valid, ev);
            else passes++;
            if (ev) begin
                o = exp_q.pop_front();
                m_out--;
                if (res_valid === 1'b1) begin
                    ref_div(o.a, o.b, eq, eo, ez);
                    checks++;
                    if (res_id !== W'(o.id))
                        $display("FAIL res_id cyc=%0d got %0d exp %0d", cyc, res_id, o.id);
                    else passes++;
                    checks++;
                    if (res_dz !== ez)
                        $display("FAIL div_zero cyc=%0d got %b exp %b", cyc, res_dz, ez);
                    else passes++;
                    checks++;
                    if (res_ovf !== eo)
                        $display("FAIL overflow cyc=%0d a=%h b=%h got %b exp %b",
                                 cyc, o.a, o.b, res_ovf, eo);
                    else passes++;
                    if (!eo || ez) begin
                        checks++;
                        if (res_quot !== eq)
                            $display("FAIL quotient cyc=%0d a=%h b=%h got %h exp %h",
                                     cyc, o.a, o.b, res_quot, eq);
                        else passes++;
                    end
                    res_log.push_back('{int'(res_id), res_quot, res_ovf, res_dz, cyc});
                end
            end
            if (g >= 0) begin
                exp_q.push_back('{g, dvd[24*g +: 24], dvs[24*g +: 24], cyc});
                grant_log.push_back('{g, cyc});
                mptr = (g + 1) % N;
                m_out++;
                issue_cnt++;
                last_g = g;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (i == last_g) req_valid[i] = 1'b0;
            if (!req_valid[i] && opq[i].size() > 0) begin
                v = opq[i].pop_front();
                dvd[24*i +: 24] = v[47:24];
                dvs[24*i +: 24] = v[23:0];
                req_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        issue_en  = 1'b1;
        req_valid = '1;
        dvd = {N{24'h000123}};
        dvs = {N{24'h000010}};
        #12;
        checks++;
        if (req_ready !== '0) $display("FAIL reset_ready got %b exp 0", req_ready);
        else passes++;
        checks++;
        if (res_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", res_valid);
        else passes++;
        checks++;
        if (res_id !== '0) $display("FAIL reset_id got %0d exp 0", res_id);
        else passes++;
        checks++;
        if (res_dz !== 1'b0) $display("FAIL reset_dz got %b exp 0", res_dz);
        else passes++;
        checks++;
        if (busy !== 1'b0 || outstanding !== 5'd0)
            $display("FAIL reset_busy got %b/%0d exp 0/0", busy, outstanding);
        else passes++;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int n0, i0, bad, mx;
        n0 = res_log.size();
        i0 = grant_log.size();
        mx = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 8; j++) opq[i].push_back(rand_op());
        for (int t = 0; t < 150 && res_log.size() < n0 + 32; t++) begin
            tick();
            if (int'(outstanding) > mx) mx = int'(outstanding);
        end
        checks++;
        if (res_log.size() != n0 + 32)
            $display("FAIL b2b_count got %0d exp 32", res_log.size() - n0);
        else begin
            passes++;
            bad = 0;
            for (int k = 0; k < 32; k++)
                if (grant_log[i0+k].id != k % N) bad++;
            checks++;
            if (bad != 0) $display("FAIL b2b_order got %0d wrong exp 0", bad);
            else passes++;
            checks++;
            if (res_log[n0+31].c - res_log[n0].c != 31)
                $display("FAIL b2b_spacing got %0d exp 31", res_log[n0+31].c - res_log[n0].c);
            else passes++;
            checks++;
            if (res_log[n0].c - grant_log[i0].c != 26)
                $display("FAIL b2b_latency got %0d exp 26", res_log[n0].c - grant_log[i0].c);
            else passes++;
        end
        checks++;
        if (mx != 26) $display("FAIL b2b_max_outstanding got %0d exp 26", mx);
        else passes++;
    endtask

    task automatic test_single();
        int n0;
        n0 = res_log.size();
        opq[0].push_back({24'h000800, 24'h001000});
        for (int t = 0; t < 40 && res_log.size() <= n0; t++) tick();
        checks++;
        if (res_log.size() <= n0) $display("FAIL single_timeout got 0 results exp 1");
        else if (res_log[n0].q !== 26'h0800000 || res_log[n0].ovf !== 1'b0 || res_log[n0].id != 0)
            $display("FAIL single got q=%h ovf=%b id=%0d exp q=0800000 ovf=0 id=0",
                     res_log[n0].q, res_log[n0].ovf, res_log[n0].id);
        else passes++;
    endtask

    task automatic test_div_zero();
        int n0;
        n0 = res_log.size();
        opq[2].push_back({24'd5, 24'd0});
        for (int t = 0; t < 40 && res_log.size() <= n0; t++) tick();
        checks++;
        if (res_log.size() <= n0) $display("FAIL divzero_timeout got 0 results exp 1");
        else if (res_log[n0].q !== 26'h3FFFFFF || res_log[n0].ovf !== 1'b1 ||
                 res_log[n0].dz !== 1'b1 || res_log[n0].id != 2)
            $display("FAIL divzero got q=%h ovf=%b dz=%b id=%0d exp 3ffffff/1/1/2",
                     res_log[n0].q, res_log[n0].ovf, res_log[n0].dz, res_log[n0].id);
        else passes++;
    endtask

    task automatic test_overflow();
        int n0;
        n0 = res_log.size();
        opq[1].push_back({24'h002000, 24'h001000});
        opq[1].push_back({24'h000FFF, 24'h001000});
        for (int t = 0; t < 50 && res_log.size() < n0 + 2; t++) tick();
        checks++;
        if (res_log.size() < n0 + 2) $display("FAIL ovf_timeout got %0d results exp 2",
                                              res_log.size() - n0);
        else begin
            passes++;
            checks++;
            if (res_log[n0].ovf !== 1'b1)
                $display("FAIL ovf_two got %b exp 1", res_log[n0].ovf);
            else passes++;
            checks++;
            if (res_log[n0+1].ovf !== 1'b0 || res_log[n0+1].q !== 26'h0FFF000)
                $display("FAIL ovf_below_one got ovf=%b q=%h exp 0/0fff000",
                         res_log[n0+1].ovf, res_log[n0+1].q);
            else passes++;
        end
    endtask

    task automatic test_drain();
        int i0, n0;
        i0 = issue_cnt;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 4; j++) opq[i].push_back(rand_op());
        for (int t = 0; t < 60 && issue_cnt < i0 + 10; t++) tick();
        issue_en = 1'b0;
        checks++;
        if (outstanding !== 5'd10) $display("FAIL drain_start got %0d exp 10", outstanding);
        else passes++;
        for (int i = 0; i < N; i++) opq[i].delete();
        req_valid = '0;
        n0 = res_log.size();
        for (int t = 0; t < 60 && busy !== 1'b0; t++) tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL drain_busy got %b exp 0", busy);
        else passes++;
        checks++;
        if (issue_cnt != i0 + 10) $display("FAIL drain_issued got %0d exp 10", issue_cnt - i0);
        else passes++;
        checks++;
        if (res_log.size() != n0 + 10)
            $display("FAIL drain_results got %0d exp 10", res_log.size() - n0);
        else passes++;
        if (res_log.size() > n0) begin
            checks++;
            if (res_log[res_log.size()-1].c + 1 != cyc)
                $display("FAIL drain_busy_fall got %0d exp %0d", cyc,
                         res_log[res_log.size()-1].c + 1);
            else passes++;
        end
        issue_en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int stale, i0, n0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 6; j++) opq[i].push_back(rand_op());
        for (int t = 0; t < 40 && m_out < 15; t++) tick();
        checks++;
        if (outstanding !== 5'd15) $display("FAIL midrst_inflight got %0d exp 15", outstanding);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || outstanding !== 5'd0 || req_ready !== '0)
            $display("FAIL midrst_clear got v=%b b=%b o=%0d r=%b exp 0/0/0/0",
                     res_valid, busy, outstanding, req_ready);
        else passes++;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        stale = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (res_valid === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) $display("FAIL midrst_stale got %0d exp 0", stale);
        else passes++;
        i0 = grant_log.size();
        n0 = res_log.size();
        opq[3].push_back(rand_op());
        opq[0].push_back(rand_op());
        for (int t = 0; t < 50 && res_log.size() < n0 + 2; t++) tick();
        checks++;
        if (grant_log.size() < i0 + 2) $display("FAIL midrst_grants got %0d exp 2",
                                               grant_log.size() - i0);
        else if (grant_log[i0].id != 0 || grant_log[i0+1].id != 3)
            $display("FAIL midrst_ptr got %0d,%0d exp 0,3",
                     grant_log[i0].id, grant_log[i0+1].id);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_div_zero();
        test_overflow();
        test_drain();
        test_reset_midflight();
        for (int t = 0; t < 60 && exp_q.size() > 0; t++) tick();
        checks++;
        if (exp_q.size() != 0) $display("FAIL final_drain got %0d pending exp 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
